aes_selftest_ctrl: RTL and testbench

Host-side initiator for the aes_core enc/dec loopback interface. It drives that interface's init/next handshake, key and block inputs, and observes its finished and compare outputs.
- Runs a programmable burst of pseudo-random blocks through the core and tallies pass/fail.
- Enforces a per-block watchdog.
- Sits between the system control logic and the AES core, replacing manual testbench sequencing of init/next.

---
 rtl/aes_selftest_ctrl_if.sv | 41 ++++
 rtl/aes_selftest_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_aes_selftest_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/aes_selftest_ctrl_if.sv
// Bundles the host control/status bus and the aes_core loopback bus of aes_selftest_ctrl.
// master = the controller's view, slave = the host/core environment's view.
interface aes_selftest_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic [CNT_W-1:0] num_blocks;
  logic [255:0]     key_in;
  logic             keylen_in;
  logic [127:0]     seed;

  logic             busy;
  logic             done;
  logic             timeout_err;
  logic [CNT_W-1:0] pass_count;
  logic [CNT_W-1:0] fail_count;
  logic [127:0]     last_result;

  logic             core_init;
  logic             core_next;
  logic [255:0]     core_key;
  logic             core_keylen;
  logic [127:0]     core_block;
  logic             core_finished;
  logic             core_comp_result;
  logic [127:0]     core_result;

  modport master (
    input  start, num_blocks, key_in, keylen_in, seed,
    input  core_finished, core_comp_result, core_result,
    output busy, done, timeout_err, pass_count, fail_count, last_result,
    output core_init, core_next, core_key, core_keylen, core_block
  );

  modport slave (
    output start, num_blocks, key_in, keylen_in, seed,
    output core_finished, core_comp_result, core_result,
    input  busy, done, timeout_err, pass_count, fail_count, last_result,
    input  core_init, core_next, core_key, core_keylen, core_block
  );
endinterface

// File: rtl/aes_selftest_ctrl.sv
// Burst self-test initiator for aes_core: init/key wait, then per block LOAD, 2-cycle next, wait, check.
// Block latency 4 cycles + core latency; start is ignored while busy, core_finished outside WAIT_FIN ignored.
module aes_selftest_ctrl #(
  parameter int KEY_WAIT_CYCLES = 32,
  parameter int TIMEOUT_CYCLES  = 255,
  parameter int CNT_W           = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  aes_selftest_ctrl_if.master bus
);

  localparam int KW_W = $clog2(KEY_WAIT_CYCLES + 1);
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEY_INIT,
    S_KEY_WAIT,
    S_LOAD,
    S_NEXT_PULSE,
    S_WAIT_FIN,
    S_CHECK,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [255:0]     r_key;
  logic             r_keylen;
  logic [CNT_W-1:0] r_num;
  logic [127:0]     r_lfsr;
  logic [KW_W-1:0]  r_wait;
  logic [WD_W-1:0]  r_wd;
  logic             r_pulse;
  logic [CNT_W-1:0] r_blk_cnt;
  logic [CNT_W-1:0] r_pass;
  logic [CNT_W-1:0] r_fail;
  logic [127:0]     r_last;
  logic             r_cmp;
  logic [127:0]     r_ct;
  logic             r_timeout;
  logic             r_skip;

  logic             w_wait_end;
  logic             w_wd_end;
  logic [CNT_W-1:0] w_blk_inc;
  logic             w_init;
  logic             w_next;
  logic             w_busy;
  logic             w_done;

  function automatic logic [127:0] lfsr_step(input logic [127:0] s);
    lfsr_step = {s[126:0], 1'b0} ^ (s[127] ? 128'h87 : 128'h0);
  endfunction

  assign w_wait_end = (r_wait == KW_W'(KEY_WAIT_CYCLES - 1));
  assign w_wd_end   = (r_wd == WD_W'(TIMEOUT_CYCLES - 1));
  assign w_blk_inc  = r_blk_cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_init      = 1'b0;
    w_next      = 1'b0;
    w_busy      = 1'b1;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        w_busy = 1'b0;
        // r_skip hides done for one cycle after a zero-length run is accepted
        w_done = (r_state == S_DONE) && !r_skip;
        if (bus.start) begin
          w_state_nxt = (bus.num_blocks == '0) ? S_DONE : S_KEY_INIT;
        end
      end
      S_KEY_INIT: begin
        w_init      = 1'b1;
        w_state_nxt = S_KEY_WAIT;
      end
      S_KEY_WAIT: begin
        if (w_wait_end) begin
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        w_state_nxt = S_NEXT_PULSE;
      end
      S_NEXT_PULSE: begin
        w_next = 1'b1;
        if (r_pulse) begin
          w_state_nxt = S_WAIT_FIN;
        end
      end
      S_WAIT_FIN: begin
        if (bus.core_finished) begin
          w_state_nxt = S_CHECK;
        end else if (w_wd_end) begin
          w_state_nxt = S_DONE;
        end
      end
      S_CHECK: begin
        w_state_nxt = (w_blk_inc == r_num) ? S_DONE : S_LOAD;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_key     <= '0;
      r_keylen  <= 1'b0;
      r_num     <= '0;
      r_lfsr    <= '0;
      r_wait    <= '0;
      r_wd      <= '0;
      r_pulse   <= 1'b0;
      r_blk_cnt <= '0;
      r_pass    <= '0;
      r_fail    <= '0;
      r_last    <= '0;
      r_cmp     <= 1'b0;
      r_ct      <= '0;
      r_timeout <= 1'b0;
      r_skip    <= 1'b0;
    end else begin
      r_skip <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_key     <= bus.key_in;
            r_keylen  <= bus.keylen_in;
            r_num     <= bus.num_blocks;
            // an all-zero state would lock the LFSR at zero
            r_lfsr    <= (bus.seed == '0) ? 128'h1 : bus.seed;
            r_blk_cnt <= '0;
            r_pass    <= '0;
            r_fail    <= '0;
            r_timeout <= 1'b0;
            r_skip    <= (bus.num_blocks == '0);
          end
        end
        S_KEY_INIT: begin
          r_wait <= '0;
        end
        S_KEY_WAIT: begin
          r_wait <= r_wait + KW_W'(1);
        end
        S_NEXT_PULSE: begin
          r_pulse <= ~r_pulse;
          r_wd    <= '0;
        end
        S_WAIT_FIN: begin
          if (bus.core_finished) begin
            r_cmp <= bus.core_comp_result;
            r_ct  <= bus.core_result;
          end else if (w_wd_end) begin
            r_timeout <= 1'b1;
          end else begin
            r_wd <= r_wd + WD_W'(1);
          end
        end
        S_CHECK: begin
          if (r_cmp) begin
            if (r_pass != '1) begin
              r_pass <= r_pass + CNT_W'(1);
            end
          end else begin
            if (r_fail != '1) begin
              r_fail <= r_fail + CNT_W'(1);
            end
          end
          r_last    <= r_ct;
          r_lfsr    <= lfsr_step(r_lfsr);
          r_blk_cnt <= w_blk_inc;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy        = w_busy;
  assign bus.done        = w_done;
  assign bus.timeout_err = r_timeout;
  assign bus.pass_count  = r_pass;
  assign bus.fail_count  = r_fail;
  assign bus.last_result = r_last;
  assign bus.core_init   = w_init;
  assign bus.core_next   = w_next;
  assign bus.core_key    = r_key;
  assign bus.core_keylen = r_keylen;
  assign bus.core_block  = r_lfsr;

endmodule

// File: tb/tb_aes_selftest_ctrl.sv
// Directed bench for aes_selftest_ctrl with a behavioural aes_core stub driven on the falling edge.
`timescale 1ns/1ps
module tb_aes_selftest_ctrl;
  localparam int CNT_W = 16;
  localparam int LAT   = 5;
  localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  aes_selftest_ctrl_if #(.CNT_W(CNT_W)) bus ();

  aes_selftest_ctrl #(
    .KEY_WAIT_CYCLES(32),
    .TIMEOUT_CYCLES (255),
    .CNT_W          (CNT_W)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  typedef struct {
    logic [CNT_W-1:0] nb;
    logic             kl;
    logic [255:0]     key;
    logic [127:0]     seed;
    int               fail_idx;
    bit               hang;
    bit               mid;
    int               exp_pass;
    int               exp_fail;
    bit               exp_to;
    int               exp_cyc;
    bit               chk_b1;
    logic [127:0]     b1;
  } vec_t;

  vec_t vecs[9];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [639:0] act, input logic [639:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic string nm(input int i, input string s);
    return $sformatf("v%0d_%s", i, s);
  endfunction

  function automatic logic [127:0] lfsr_step(input logic [127:0] s);
    return {s[126:0], 1'b0} ^ (s[127] ? 128'h87 : 128'h0);
  endfunction

  function automatic logic [127:0] stub_ct(input logic [127:0] b);
    return (b == FIPS_PT) ? FIPS_CT : (b ^ 128'h5a5a5a5a_a5a5a5a5_0f0f0f0f_f0f0f0f0);
  endfunction

  task automatic run(input int idx, input vec_t v, input int rst_at);
    logic [127:0] blks[$];
    logic [127:0] lat_blk = '0;
    logic [127:0] s;
    logic [127:0] last_blk = '0;
    logic [255:0] key_seen = '0;
    logic         kl_seen = 1'b0;
    logic         busy1 = 1'b0;
    int cyc = 0, init_n = 0, next_n = 0, nrun = 0, bad_run = 0, last_next = 0;
    int cnt = 0, fired = 0, issued;
    bit fin = 0, aborted = 0;

    @(negedge clk);
    bus.num_blocks = v.nb;
    bus.key_in     = v.key;
    bus.keylen_in  = v.kl;
    bus.seed       = v.seed;
    bus.start      = 1'b1;
    while (!fin) begin
      @(negedge clk);
      cyc++;
      bus.start = v.mid && (cyc == 20);
      if (cyc == 1) busy1 = bus.busy;
      if (bus.core_init) init_n++;
      if (bus.core_next) begin
        if (nrun == 0) begin
          blks.push_back(bus.core_block);
          key_seen = bus.core_key;
          kl_seen  = bus.core_keylen;
        end
        nrun++;
        next_n++;
        last_next = cyc;
      end else if (nrun != 0) begin
        if (nrun != 2) bad_run++;
        nrun = 0;
      end
      bus.core_finished = 1'b0;
      if (bus.core_next) begin
        cnt     = LAT;
        lat_blk = bus.core_block;
      end else if (cnt != 0) begin
        cnt--;
        if (cnt == 0 && !v.hang) begin
          bus.core_finished    = 1'b1;
          bus.core_result      = stub_ct(lat_blk);
          bus.core_comp_result = (fired != v.fail_idx);
          fired++;
        end
      end
      if (rst_at != 0 && cyc == rst_at) begin
        check(nm(idx, "pre_rst_busy"), bus.busy, 1);
        #2 reset_n = 1'b0;
        #1;
        check(nm(idx, "rst_outputs"),
              {bus.busy, bus.done, bus.timeout_err, bus.pass_count, bus.fail_count,
               bus.last_result, bus.core_init, bus.core_next, bus.core_key,
               bus.core_keylen, bus.core_block}, 0);
        bus.core_finished = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        fin = 1;
        aborted = 1;
      end else if (bus.done) begin
        fin = 1;
      end else if (cyc >= 2000) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s: done not seen after %0d cycles", nm(idx, "run_bound"), cyc);
        fin = 1;
      end
    end
    if (!aborted) begin
      issued = (v.nb == 0) ? 0 : (v.hang ? 1 : int'(v.nb));
      check(nm(idx, "pass"), bus.pass_count, v.exp_pass);
      check(nm(idx, "fail"), bus.fail_count, v.exp_fail);
      check(nm(idx, "timeout"), bus.timeout_err, v.exp_to);
      check(nm(idx, "done_busy"), {bus.done, bus.busy}, 2'b10);
      check(nm(idx, "busy_c1"), busy1, (v.nb != 0));
      check(nm(idx, "cycles"), cyc, v.exp_cyc);
      check(nm(idx, "init_cnt"), init_n, (v.nb != 0) ? 1 : 0);
      check(nm(idx, "next_cnt"), next_n, 2 * issued);
      check(nm(idx, "next_width"), bad_run, 0);
      check(nm(idx, "nblk"), blks.size(), issued);
      s = (v.seed == '0) ? 128'h1 : v.seed;
      for (int k = 0; k < issued && k < int'(blks.size()); k++) begin
        check(nm(idx, $sformatf("blk%0d", k)), blks[k], s);
        last_blk = s;
        s = lfsr_step(s);
      end
      if (issued != 0) begin
        check(nm(idx, "core_key"), {key_seen, kl_seen}, {v.key, v.kl});
      end
      if (issued != 0 && !v.hang) begin
        check(nm(idx, "last_result"), bus.last_result, stub_ct(last_blk));
      end
      if (v.hang) begin
        check(nm(idx, "wait_fin_len"), cyc - last_next, 256);
      end
      if (v.seed == '0 && blks.size() > 0) begin
        check(nm(idx, "seed0_first"), blks[0], 128'h1);
      end
      if (v.chk_b1 && blks.size() > 1) begin
        check(nm(idx, "blk1_hand"), blks[1], v.b1);
      end
      if (v.seed == FIPS_PT && v.nb == 1) begin
        check(nm(idx, "fips_ct"), bus.last_result, FIPS_CT);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.start = 1'b0;
    bus.num_blocks = '0;
    bus.key_in = '0;
    bus.keylen_in = 1'b0;
    bus.seed = '0;
    bus.core_finished = 1'b0;
    bus.core_comp_result = 1'b0;
    bus.core_result = '0;

    //        nb  kl  key   seed                                       fidx hang mid pass fail to cyc  b1?  b1
    vecs[0] = '{16'd1, 1'b0, K128, FIPS_PT,                                 -1, 0, 0, 1, 0, 0, 43,  0, 128'h0};
    vecs[1] = '{16'd8, 1'b1, K256, 128'hdeadbeef_01234567_89abcdef_cafef00d, -1, 0, 0, 8, 0, 0, 106, 0, 128'h0};
    vecs[2] = '{16'd5, 1'b0, K128, 128'h13579bdf_2468ace0_0badf00d_feedface,  2, 0, 0, 4, 1, 0, 79,  0, 128'h0};
    vecs[3] = '{16'd3, 1'b0, K128, 128'h0000ffff_0000ffff_0000ffff_0000ffff, -1, 1, 0, 0, 0, 1, 292, 0, 128'h0};
    vecs[4] = '{16'd2, 1'b0, K128, 128'h0000ffff_0000ffff_0000ffff_0000ffff, -1, 0, 0, 2, 0, 0, 52,  0, 128'h0};
    vecs[5] = '{16'd0, 1'b1, K256, 128'h1234,                                -1, 0, 0, 0, 0, 0, 2,   0, 128'h0};
    vecs[6] = '{16'd2, 1'b0, K128, 128'h0,                                   -1, 0, 0, 2, 0, 0, 52,  1, 128'h2};
    vecs[7] = '{16'd2, 1'b1, K256, 128'h80000000_00000000_00000000_00000001, -1, 0, 0, 2, 0, 0, 52,  1, 128'h85};
    vecs[8] = '{16'd3, 1'b0, K128, 128'hcafebabe_cafebabe_cafebabe_cafebabe, -1, 0, 1, 3, 0, 0, 61,  0, 128'h0};

    #1 reset_n = 1'b0;
    #2;
    check("reset_state",
          {bus.busy, bus.done, bus.timeout_err, bus.pass_count, bus.fail_count,
           bus.last_result, bus.core_init, bus.core_next, bus.core_key,
           bus.core_keylen, bus.core_block}, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run(i, vecs[i], 0);
    end

    // abort in WAIT_FIN, then a clean run from IDLE
    run(9, vecs[1], 38);
    run(10, vecs[0], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
